// File: rtl/keycode_event_unit.sv
// Keycode event unit: filters the raw USB keycode and queues PRESS/RELEASE(/REPEAT) events.
// Optional auto-repeat generation is enabled by defining KEYEVT_REPEAT_EN.
module keycode_event_unit #(
    parameter int DEBOUNCE_CYC     = 4,
    parameter int FIFO_DEPTH       = 8,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    keycode,
    input  logic                          evt_ready,
    input  logic                          ovf_clr,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic [1:0]                    evt_type,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic [7:0]                    held_code,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STAB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REL  = 2'd1,
        ST_PRS  = 2'd2
    } state_t;

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if ((REPEAT_DELAY_CYC < 1) || (REPEAT_RATE_CYC < 1)) begin : g_bad_repeat
        $error("REPEAT_DELAY_CYC and REPEAT_RATE_CYC must be at least 1");
    end

    logic [7:0]        kc_q_r;
    logic [7:0]        cand_r;
    logic [STAB_W-1:0] stab_cnt_r;
    logic [7:0]        held_r;
    logic [7:0]        old_r;
    state_t            state_r;
    logic              commit_s;
    logic              rpt_fire_s;

    logic              push_s;
    logic [9:0]        push_data_s;
    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [9:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  remain_s;
    logic [9:0]        head_r;
    logic [9:0]        head_nxt_s;
    logic              evt_valid_r;
    logic              overflow_r;

    // Input register and stability filter on the registered keycode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q_r     <= 8'h00;
            cand_r     <= 8'h00;
            stab_cnt_r <= {STAB_W{1'b0}};
        end else begin
            kc_q_r <= keycode;
            if (kc_q_r != cand_r) begin
                cand_r     <= kc_q_r;
                stab_cnt_r <= {STAB_W{1'b0}};
            end else if (stab_cnt_r != STAB_MAX) begin
                stab_cnt_r <= stab_cnt_r + STAB_W'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // The counter saturates, so a commit blocked by a busy FSM stays pending.
    assign commit_s = (stab_cnt_r == STAB_MAX) && (cand_r != held_r) && (state_r == ST_IDLE);

    // Event sequencer: a key change emits RELEASE of the old key, then PRESS of the new
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            held_r  <= 8'h00;
            old_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (commit_s) begin
                        old_r  <= held_r;
                        held_r <= cand_r;
                        if (held_r != 8'h00) begin
                            state_r <= ST_REL;
                        end else if (cand_r != 8'h00) begin
                            state_r <= ST_PRS;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REL: begin
                    state_r <= (held_r != 8'h00) ? ST_PRS : ST_IDLE;
                end
                ST_PRS: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KEYEVT_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_r;
    logic             rpt_phase_r;
    logic [RPT_W-1:0] rpt_lim_s;
    logic             rpt_run_s;

    assign rpt_run_s  = (state_r == ST_IDLE) && (held_r != 8'h00);
    assign rpt_lim_s  = rpt_phase_r ? RPT_W'(REPEAT_RATE_CYC - 1) : RPT_W'(REPEAT_DELAY_CYC - 1);
    assign rpt_fire_s = rpt_run_s && !commit_s && (rpt_cnt_r == rpt_lim_s);

    // Auto-repeat timer: initial delay phase, then fixed-rate phase until the next commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_r   <= {RPT_W{1'b0}};
            rpt_phase_r <= 1'b0;
        end else if (commit_s) begin
            rpt_cnt_r   <= {RPT_W{1'b0}};
            rpt_phase_r <= 1'b0;
        end else if (rpt_run_s) begin
            if (rpt_cnt_r == rpt_lim_s) begin
                rpt_cnt_r   <= {RPT_W{1'b0}};
                rpt_phase_r <= 1'b1;
            end else begin
                rpt_cnt_r   <= rpt_cnt_r + RPT_W'(1);
                rpt_phase_r <= rpt_phase_r;
            end
        end else begin
            rpt_cnt_r   <= rpt_cnt_r;
            rpt_phase_r <= rpt_phase_r;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Push request: sequencer states and repeats are mutually exclusive, so one push per cycle
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 10'h000;
        case (state_r)
            ST_REL: begin
                push_s      = 1'b1;
                push_data_s = {old_r, EVT_RELEASE};
            end
            ST_PRS: begin
                push_s      = 1'b1;
                push_data_s = {held_r, EVT_PRESS};
            end
            ST_IDLE: begin
                if (rpt_fire_s) begin
                    push_s      = 1'b1;
                    push_data_s = {held_r, EVT_REPEAT};
                end else begin
                    push_s      = 1'b0;
                    push_data_s = 10'h000;
                end
            end
            default: begin
                push_s      = 1'b0;
                push_data_s = 10'h000;
            end
        endcase
    end

    assign pop_s     = evt_valid_r & evt_ready;
    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;
    assign remain_s  = count_r - {{(CNT_W-1){1'b0}}, pop_s};

    // Next FIFO occupancy and next head word (head is registered for first-word-fall-through)
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_ok_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end

        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end

        if (count_nxt_s == {CNT_W{1'b0}}) begin
            head_nxt_s = 10'h000;
        end else if (remain_s == {CNT_W{1'b0}}) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage, pointers, registered head and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'h000;
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            head_r      <= 10'h000;
            evt_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            evt_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_code  = head_r[9:2];
    assign evt_type  = head_r[1:0];
    assign evt_count = count_r;
    assign held_code = held_r;
    assign overflow  = overflow_r;

endmodule
